scoreboard_cmp_fifo: RTL

//  Multi-channel in-order scoreboard for the lpcm testbench. Holds expected

---
 rtl/scoreboard_cmp_fifo.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/scoreboard_cmp_fifo.sv
// Multi-channel in-order scoreboard: one circular expected-word queue per channel,
// each actual word is compared against the head of its channel's queue.
module scoreboard_cmp_fifo #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned BITS     = 32,
  parameter int unsigned CNT_BITS = 16,
  parameter bit          ERR_MSG  = 1'b1,
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                exp_vld,
  input  logic [CH_W-1:0]     exp_ch,
  input  logic [BITS-1:0]     exp_data,
  input  logic                act_vld,
  input  logic [CH_W-1:0]     act_ch,
  input  logic [BITS-1:0]     act_data,
  output logic                res_vld,
  output logic                res_ok,
  output logic [CH_W-1:0]     res_ch,
  output logic [BITS-1:0]     res_exp,
  output logic [BITS-1:0]     res_act,
  output logic [CNT_BITS-1:0] match_cnt,
  output logic [CNT_BITS-1:0] mismatch_cnt,
  output logic                overflow,
  output logic                underflow,
  output logic [CHANNELS-1:0] ch_empty,
  output logic                all_empty
);

  localparam int unsigned PTR_W = $clog2(ENTRIES);
  localparam int unsigned CNT_W = $clog2(ENTRIES + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(ENTRIES);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(ENTRIES - 1);

  logic [BITS-1:0]  mem    [CHANNELS][ENTRIES];
  logic [PTR_W-1:0] rd_ptr [CHANNELS];
  logic [PTR_W-1:0] wr_ptr [CHANNELS];
  logic [CNT_W-1:0] count  [CHANNELS];

  logic            exp_in, act_in, exp_bad, act_bad;
  logic            same, act_empty, exp_full;
  logic            bypass, pop, push, drop, under, cmp;
  logic [CH_W-1:0] exp_idx, act_idx;
  logic [BITS-1:0] cmp_exp;
  logic [CHANNELS-1:0] inc, dec;
  logic            rst_q;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Decode of the cycle's push/pop/bypass/error events; flush masks everything.
  always_comb begin
    exp_in    = exp_vld && !flush && (32'(exp_ch) < CHANNELS);
    act_in    = act_vld && !flush && (32'(act_ch) < CHANNELS);
    exp_bad   = exp_vld && !flush && !(32'(exp_ch) < CHANNELS);
    act_bad   = act_vld && !flush && !(32'(act_ch) < CHANNELS);
    exp_idx   = exp_in ? exp_ch : '0;
    act_idx   = act_in ? act_ch : '0;
    act_empty = (count[act_idx] == '0);
    exp_full  = (count[exp_idx] == FULL);
    same      = exp_in && act_in && (exp_ch == act_ch);
    bypass    = same && act_empty;
    pop       = act_in && !act_empty;
    push      = exp_in && !bypass && (!exp_full || same);
    drop      = exp_in && exp_full && !same;
    under     = act_in && act_empty && !same;
    cmp       = pop || bypass;
    cmp_exp   = bypass ? exp_data : mem[act_idx][rd_ptr[act_idx]];
    inc       = '0;
    dec       = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      inc[c]      = push && (exp_idx == CH_W'(c));
      dec[c]      = pop && (act_idx == CH_W'(c));
      ch_empty[c] = (count[c] == '0);
    end
    all_empty = &ch_empty;
  end

  // Queue storage needs no reset; pointers/counts qualify its contents.
  always_ff @(posedge clk) begin
    if (push) mem[exp_idx][wr_ptr[exp_idx]] <= exp_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        if (flush) begin
          rd_ptr[c] <= '0;
          wr_ptr[c] <= '0;
          count[c]  <= '0;
        end else begin
          if (inc[c]) wr_ptr[c] <= nxt(wr_ptr[c]);
          if (dec[c]) rd_ptr[c] <= nxt(rd_ptr[c]);
          if (inc[c] && !dec[c])      count[c] <= count[c] + 1'b1;
          else if (dec[c] && !inc[c]) count[c] <= count[c] - 1'b1;
        end
      end
    end
  end

  // Registered compare result, saturating counters and sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld      <= 1'b0;
      res_ok       <= 1'b0;
      res_ch       <= '0;
      res_exp      <= '0;
      res_act      <= '0;
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      res_vld   <= cmp;
      overflow  <= overflow | drop;
      underflow <= underflow | under;
      if (cmp) begin
        res_ok  <= (cmp_exp == act_data);
        res_ch  <= act_ch;
        res_exp <= cmp_exp;
        res_act <= act_data;
        if (cmp_exp == act_data) begin
          if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
        end else begin
          if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 1'b0;
    else        rst_q <= 1'b1;
  end

  always @(posedge clk) begin
    if (rst_n && ERR_MSG) begin
      if (drop)    $error("scoreboard: push dropped, channel %0d full", exp_ch);
      if (under)   $error("scoreboard: actual on empty channel %0d", act_ch);
      if (exp_bad) $error("scoreboard: expected channel %0d out of range", exp_ch);
      if (act_bad) $error("scoreboard: actual channel %0d out of range", act_ch);
      if (cmp && (cmp_exp != act_data))
        $error("scoreboard: mismatch ch=%0d exp=%h act=%h", act_ch, cmp_exp, act_data);
    end
  end

  a_res_known: assert property (@(posedge clk) disable iff (!rst_n)
    res_vld |-> !$isunknown({res_exp, res_act}));
  a_no_res_after_rst: assert property (@(posedge clk) (rst_n && !rst_q) |-> !res_vld);

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_cnt_chk
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) count[g] <= FULL);
  end

endmodule
